result_display: RTL and testbench
=================================

Name: result_display

Overview:
Downstream stage of the 4-bit calculator. Registers the 8-bit calculator result on a load strobe and converts it to 3-digit BCD with a sequential shift-add-3 (double-dabble) engine. Drives a time-multiplexed, active-low 4-digit 7-segment display with leading-zero blanking.

Parameters:
CLK_DIV, 100000, clk cycles each digit stays lit before the scan advances; legal range is 2 or more.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
value  input  8  unsigned calculator result
load  input  1  one-cycle strobe; capture value and start conversion
busy  output  1  high while a conversion is running
done  output  1  one-cycle pulse when bcd updates
bcd  output  12  {hundreds, tens, ones}, each 4 bits
seg  output  7  segments {g,f,e,d,c,b,a}, active-low
an  output  4  digit enables, active-low; an[0] is the ones digit
dp  output  1  decimal point, active-low; tied to 1 (off)

Behaviour:
- Clock and reset: single clock, clk; rst is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values: busy=0, done=0, bcd=12'h000, FSM=IDLE, scan counter=0, digit index=0. After reset the outputs are an=4'b1110, seg=7'b1000000 (shows "0"), dp=1.
- FSM states: IDLE and SHIFT.
- IDLE:
  - When load=1 at edge k: latch value into shift reg, clear the BCD working reg, set iteration count=0, go to SHIFT.
  - busy=1 from edge k.
- SHIFT, one iteration per cycle:
  - Add 3 to each working nibble that is 5 or more.
  - Then shift {bcd_work, bin} left by 1.
  - Increment the iteration count.
- Completion:
  - The 8th iteration completes at edge k+8.
  - That same edge writes the result to bcd, sets done=1 for exactly one cycle, sets busy=0 and returns to IDLE.
  - Latency from load sampled to bcd valid is 8 cycles.
- bcd holds its previous value throughout a conversion. It changes only on completion.
- load while busy=1 is ignored. The conversion in progress is unaffected and there is no queueing.
- load is accepted again at the edge after busy falls.
- rst during SHIFT aborts the conversion. All reset values apply on the next edge and no done pulse is issued.
- value range is 0..255, so the hundreds digit is 0..2. The conversion is exact for all 256 inputs.
- Scan counter:
  - Counts 0..CLK_DIV-1, then wraps to 0.
  - On the wrap the digit index advances 0→1→2→3→0.
  - Runs continuously and independently of the FSM.
- Digit index selects the display:
  - 0: ones, an=1110
  - 1: tens, an=1101
  - 2: hundreds, an=1011
  - 3: unused, an=1111
- Leading-zero blanking:
  - Hundreds is blanked (an=1111) when hundreds=0.
  - Tens is blanked when hundreds=0 and tens=0.
  - Ones is always shown.
- Segment decode (gfedcba, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Any other nibble decodes to 1111111.
- seg and an are combinational from the digit index and bcd. The display updates in the same cycle that bcd changes.

Test Plan:
- Reset: rst=1 for 2 cycles, then release. Expect bcd=000, busy=0, done=0, an=1110, seg=1000000.
- Full-scale conversion: load with value=255. Expect busy high for 8 cycles, then bcd=12'h255 with a single done pulse. Run all 256 values against a reference model.
- Blanking (CLK_DIV=4): load value=7, then run 16 cycles. Expect the ones slot to show seg=1111000 and an=1111 in the tens, hundreds and unused slots. Repeat with value=40: tens shows 4 (0011001), ones shows 0, hundreds blank.
- Load while busy: load 200, then at cycle +3 load 99. Expect bcd=200 at cycle +8 with exactly one done pulse, and 99 never appears. A load issued the cycle after done is accepted.
- Reset mid-conversion: load 128, assert rst at cycle +4. Expect busy=0, bcd=000 and no done pulse. A following load 128 gives bcd=12'h128.
- Scan order (CLK_DIV=4): with bcd=255, check that an cycles 1110, 1101, 1011, 1111, each held exactly 4 cycles, then repeats.

Source files
------------

// File: rtl/result_display.sv
// rtl/result_display.sv - registered 8-bit to 3-digit BCD converter with multiplexed 7-segment drive
module result_display #(
  parameter int CLK_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  value,
  input  logic        load,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        dp
);

  localparam int CW = $clog2(CLK_DIV);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state, state_nx;
  logic [7:0]    bin;
  logic [11:0]   work;
  logic [2:0]    iter;
  logic [11:0]   work_adj;
  logic [11:0]   work_sh;
  logic          last_iter;
  logic [CW-1:0] scan_cnt;
  logic [1:0]    digit_idx;
  logic [3:0]    digit;

  assign dp = 1'b1;

  // Shift-add-3 step: correct each BCD nibble that would overflow after doubling, then shift.
  always_comb begin
    work_adj = work;
    for (int i = 0; i < 3; i++) begin
      if (work[i*4 +: 4] >= 4'd5) begin
        work_adj[i*4 +: 4] = work[i*4 +: 4] + 4'd3;
      end
    end
    work_sh   = {work_adj[10:0], bin[7]};
    last_iter = (iter == 3'd7);
  end

  // Next-state logic; busy simply reflects the conversion state.
  always_comb begin
    state_nx = state;
    busy     = (state == SHIFT);
    case (state)
      IDLE:    if (load) state_nx = SHIFT;
      SHIFT:   if (last_iter) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Conversion datapath; bcd is only written on the final iteration so it holds during a conversion.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin  <= '0;
      work <= '0;
      iter <= '0;
      bcd  <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (load) begin
          bin  <= value;
          work <= '0;
          iter <= '0;
        end
      end else begin
        bin  <= {bin[6:0], 1'b0};
        work <= work_sh;
        iter <= iter + 3'd1;
        if (last_iter) begin
          bcd  <= work_sh;
          done <= 1'b1;
        end
      end
    end
  end

  // Free-running scan timer; advances the displayed digit every CLK_DIV cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
    end else if (scan_cnt == CW'(CLK_DIV - 1)) begin
      scan_cnt  <= '0;
      digit_idx <= digit_idx + 2'd1;
    end else begin
      scan_cnt  <= scan_cnt + CW'(1);
    end
  end

  // Digit select with leading-zero blanking and segment decode.
  always_comb begin
    digit = bcd[3:0];
    an    = 4'b1111;
    case (digit_idx)
      2'd0: begin
        digit = bcd[3:0];
        an    = 4'b1110;
      end
      2'd1: begin
        digit = bcd[7:4];
        if (bcd[11:8] != 4'd0 || bcd[7:4] != 4'd0) an = 4'b1101;
      end
      2'd2: begin
        digit = bcd[11:8];
        if (bcd[11:8] != 4'd0) an = 4'b1011;
      end
      default: an = 4'b1111;
    endcase
    seg = 7'b1111111;
    if (an != 4'b1111) begin
      case (digit)
        4'd0:    seg = 7'b1000000;
        4'd1:    seg = 7'b1111001;
        4'd2:    seg = 7'b0100100;
        4'd3:    seg = 7'b0110000;
        4'd4:    seg = 7'b0011001;
        4'd5:    seg = 7'b0010010;
        4'd6:    seg = 7'b0000010;
        4'd7:    seg = 7'b1111000;
        4'd8:    seg = 7'b0000000;
        4'd9:    seg = 7'b0010000;
        default: seg = 7'b1111111;
      endcase
    end
  end

endmodule

// File: tb/tb_result_display.sv
// tb/tb_result_display.sv - directed scoreboard bench for result_display
module tb_result_display;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  value = '0;
  logic        load = 1'b0;
  logic        busy, done, dp;
  logic [11:0] bcd;
  logic [6:0]  seg;
  logic [3:0]  an;

  int checks = 0;
  int errors = 0;
  int sc = 0;
  logic [11:0] exp_q[$];

  result_display #(.CLK_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .value(value), .load(load),
    .busy(busy), .done(done), .bcd(bcd), .seg(seg), .an(an), .dp(dp)
  );

  always #5 clk = ~clk;

  // Reference scan position: cycles since the last reset edge.
  always @(posedge clk) begin
    if (rst) sc <= 0;
    else     sc <= sc + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] ref_bcd(input int v);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {h, t, o};
  endfunction

  function automatic logic [6:0] ref_seg(input logic [3:0] d);
    logic [6:0] tbl [10];
    tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    return (d < 10) ? tbl[d] : 7'b1111111;
  endfunction

  task automatic pop_cmp(input string tag);
    logic [11:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_nonempty"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      chk(tag, bcd, e);
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    chk("done_seen", done, 1);
  endtask

  task automatic convert(input int v, input bit chk_lat);
    int n;
    value = 8'(v);
    load  = 1'b1;
    exp_q.push_back(ref_bcd(v));
    tick();
    load = 1'b0;
    chk("busy_after_load", busy, 1);
    if (chk_lat) chk("bcd_held", bcd, 12'h000);
    wait_done(n);
    if (chk_lat) chk("latency", n, 8);
    chk("busy_at_done", busy, 0);
    pop_cmp("bcd_result");
    tick();
    chk("done_one_cycle", done, 0);
  endtask

  task automatic disp_check(input int cycles, input logic [11:0] b);
    int idx;
    logic [3:0] ea, d;
    for (int i = 0; i < cycles; i++) begin
      idx = (sc / DIV) % 4;
      ea = 4'b1111;
      d  = b[3:0];
      case (idx)
        0: ea = 4'b1110;
        1: begin d = b[7:4];  if (b[11:8] != 0 || b[7:4] != 0) ea = 4'b1101; end
        2: begin d = b[11:8]; if (b[11:8] != 0) ea = 4'b1011; end
        default: ea = 4'b1111;
      endcase
      chk("an_scan", an, ea);
      if (ea != 4'b1111) chk("seg_digit", seg, ref_seg(d));
      tick();
    end
  endtask

  initial begin
    int n;
    bit saw_bad;

    // Reset
    rst = 1'b1;
    tick();
    tick();
    chk("rst_bcd", bcd, 12'h000);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_an", an, 4'b1110);
    chk("rst_seg", seg, 7'b1000000);
    chk("rst_dp", dp, 1);
    rst = 1'b0;

    // Full scale with latency, then scan order at 255
    convert(255, 1'b1);
    disp_check(40, 12'h255);

    // Blanking
    convert(7, 1'b0);
    disp_check(16, 12'h007);
    convert(40, 1'b0);
    disp_check(16, 12'h040);

    // Load while busy is ignored
    value = 8'd200;
    load  = 1'b1;
    exp_q.push_back(ref_bcd(200));
    tick();
    value = 8'd99;
    load  = 1'b0;
    tick();
    tick();
    load = 1'b1;
    tick();
    load = 1'b0;
    saw_bad = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      if (bcd == 12'h099) saw_bad = 1'b1;
      tick();
      n++;
    end
    chk("busy_load_done_seen", done, 1);
    chk("busy_load_latency", n, 5);
    chk("busy_load_no_99", saw_bad, 0);
    pop_cmp("busy_load_bcd");
    // Load issued the cycle after done
    value = 8'd99;
    load  = 1'b1;
    exp_q.push_back(ref_bcd(99));
    tick();
    load = 1'b0;
    chk("post_done_no_second_pulse", done, 0);
    chk("post_done_accept", busy, 1);
    wait_done(n);
    chk("post_done_latency", n, 8);
    pop_cmp("post_done_bcd");

    // Reset mid-conversion
    value = 8'd128;
    load  = 1'b1;
    tick();
    load = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_bcd", bcd, 12'h000);
    chk("abort_done", done, 0);
    saw_bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done) saw_bad = 1'b1;
      tick();
    end
    chk("abort_no_done", saw_bad, 0);
    convert(128, 1'b1);

    // Exhaustive values
    for (int v = 0; v < 256; v++) convert(v, 1'b0);
    disp_check(16, ref_bcd(255));

    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
